// File: rtl/mips_pc_pkg.sv
// Shared types and constants for the fetch-side program counter of the Harvard MIPS core.
package mips_pc_pkg;

    typedef enum logic {
        SEQ   = 1'b0,
        DELAY = 1'b1
    } pc_state_t;

    localparam logic [31:0] RESET_VECTOR_DEF = 32'hBFC0_0000;
    localparam logic [31:0] HALT_ADDR_DEF    = 32'h0000_0000;
    localparam logic [31:0] PC_STEP          = 32'd4;
    localparam logic [31:0] ALIGN_MASK       = 32'hFFFF_FFFC;

endpackage

// File: rtl/mips_pc_unit.sv
// Fetch program counter with MIPS branch delay slots and halt detection.
// Optional misaligned-target trap enabled by defining PC_ALIGN_CHECK_EN.
module mips_pc_unit
    import mips_pc_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEF,
    parameter logic [31:0] HALT_ADDR    = HALT_ADDR_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clk_enable,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_tgt,
    output logic [31:0] instr_address,
    output logic        delay_slot,
    output logic        active,
    output logic        addr_err
);

    pc_state_t   state_r;
    pc_state_t   state_s;
    logic [31:0] pc_r;
    logic [31:0] pc_s;
    logic [31:0] pend_tgt_r;
    logic [31:0] pend_tgt_s;
    logic        active_r;
    logic        active_s;
    logic        advance_s;

`ifdef PC_ALIGN_CHECK_EN
    logic        addr_err_r;
    logic        addr_err_s;
`endif

    assign advance_s = clk_enable & ~stall & active_r;

    // Next-state, next-PC and halt decision for one advance cycle.
    always_comb begin
        state_s    = state_r;
        pc_s       = pc_r;
        pend_tgt_s = pend_tgt_r;
        active_s   = active_r;
`ifdef PC_ALIGN_CHECK_EN
        addr_err_s = addr_err_r;
`endif
        if (advance_s) begin
            if (pc_r == HALT_ADDR) begin
                // Fetching the halt address freezes the unit where it stands.
                active_s = 1'b0;
            end else begin
                case (state_r)
                    SEQ: begin
                        pc_s = pc_r + PC_STEP;
                        if (redirect) begin
                            state_s = DELAY;
`ifdef PC_ALIGN_CHECK_EN
                            pend_tgt_s = redirect_tgt;
                            if (redirect_tgt[1:0] != 2'b00) begin
                                addr_err_s = 1'b1;
                            end else begin
                                addr_err_s = addr_err_r;
                            end
`else
                            pend_tgt_s = redirect_tgt & ALIGN_MASK;
`endif
                        end else begin
                            state_s = SEQ;
                        end
                    end
                    DELAY: begin
`ifdef PC_ALIGN_CHECK_EN
                        // A bad target lets the delay slot run, then stops instead of jumping.
                        if (addr_err_r) begin
                            active_s = 1'b0;
                        end else begin
                            pc_s    = pend_tgt_r;
                            state_s = SEQ;
                        end
`else
                        pc_s    = pend_tgt_r;
                        state_s = SEQ;
`endif
                    end
                    default: begin
                        state_s = SEQ;
                    end
                endcase
            end
        end else begin
            state_s    = state_r;
            pc_s       = pc_r;
            pend_tgt_s = pend_tgt_r;
            active_s   = active_r;
        end
    end

    // State, PC and status registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r    <= SEQ;
            pc_r       <= RESET_VECTOR;
            pend_tgt_r <= 32'h0000_0000;
            active_r   <= 1'b1;
`ifdef PC_ALIGN_CHECK_EN
            addr_err_r <= 1'b0;
`endif
        end else begin
            state_r    <= state_s;
            pc_r       <= pc_s;
            pend_tgt_r <= pend_tgt_s;
            active_r   <= active_s;
`ifdef PC_ALIGN_CHECK_EN
            addr_err_r <= addr_err_s;
`endif
        end
    end

    assign instr_address = pc_r;
    assign delay_slot    = (state_r == DELAY);
    assign active        = active_r;
`ifdef PC_ALIGN_CHECK_EN
    assign addr_err      = addr_err_r;
`else
    assign addr_err      = 1'b0;
`endif

endmodule

// File: tb/tb_mips_pc_unit.sv
// Self-checking bench for mips_pc_unit: fetch-sequence model checked every cycle plus directed literals.
module tb_mips_pc_unit;

    localparam logic [31:0] RV   = 32'hBFC0_0000;
    localparam logic [31:0] HALT = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        clk_enable = 1'b1;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_tgt = 32'h0000_0000;
    logic [31:0] instr_address;
    logic        delay_slot;
    logic        active;
    logic        addr_err;

    int n_checks = 0;
    int n_pass   = 0;

    mips_pc_unit dut (
        .clk           (clk),
        .reset         (reset),
        .clk_enable    (clk_enable),
        .stall         (stall),
        .redirect      (redirect),
        .redirect_tgt  (redirect_tgt),
        .instr_address (instr_address),
        .delay_slot    (delay_slot),
        .active        (active),
        .addr_err      (addr_err)
    );

    always #5 clk = ~clk;

    // Model: a list of scheduled fetches; a taken branch schedules its slot then its target.
    typedef struct {
        logic [31:0] a;
        bit          ds;
    } fetch_t;

    fetch_t      upcoming[$];
    logic [31:0] m_pc;
    bit          m_ds;
    bit          m_active;
    bit          m_err;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        fetch_t f;
        forever begin
            @(posedge clk or negedge reset);
            if (!reset) begin
                m_pc = RV; m_ds = 1'b0; m_active = 1'b1; m_err = 1'b0;
                upcoming.delete();
            end else if (clk_enable && !stall && m_active) begin
                if (m_pc == HALT || (m_ds && m_err)) begin
                    m_active = 1'b0;
                end else begin
                    if (!m_ds && redirect) begin
                        upcoming.push_back('{m_pc + 32'd4, 1'b1});
`ifdef PC_ALIGN_CHECK_EN
                        if (redirect_tgt % 32'd4 != 32'd0) m_err = 1'b1;
                        else upcoming.push_back('{redirect_tgt, 1'b0});
`else
                        upcoming.push_back('{redirect_tgt - (redirect_tgt % 32'd4), 1'b0});
`endif
                    end
                    if (upcoming.size() > 0) begin
                        f = upcoming.pop_front();
                        m_pc = f.a; m_ds = f.ds;
                    end else begin
                        m_pc = m_pc + 32'd4; m_ds = 1'b0;
                    end
                end
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            chk("model_pc",     instr_address,       m_pc);
            chk("model_ds",     {31'd0, delay_slot}, {31'd0, m_ds});
            chk("model_active", {31'd0, active},     {31'd0, m_active});
            chk("model_err",    {31'd0, addr_err},   {31'd0, m_err});
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2 reset = 1'b0;
        redirect = 1'b0; stall = 1'b0; clk_enable = 1'b1;
        #4 reset = 1'b1;
    endtask

    initial begin
        #7 reset = 1'b1;
        #1;
        // 1: reset state and sequential fetch
        chk("rst_pc", instr_address, RV);
        chk("rst_ds", {31'd0, delay_slot}, 32'd0);
        chk("rst_active", {31'd0, active}, 32'd1);
        chk("rst_err", {31'd0, addr_err}, 32'd0);
        tick(); chk("seq1", instr_address, 32'hBFC0_0004);
        tick(); chk("seq2", instr_address, 32'hBFC0_0008);
        tick(); chk("seq3", instr_address, 32'hBFC0_000C);
        tick(); chk("seq4", instr_address, 32'hBFC0_0010);

        // 2/3/5: branch, stalled delay slot, ignored branch in slot, clock-enable freeze
        do_reset(); tick(); tick();
        chk("br_at", instr_address, 32'hBFC0_0008);
        redirect = 1'b1; redirect_tgt = 32'hBFC0_0018;
        tick(); chk("br_slot", instr_address, 32'hBFC0_000C);
        chk("br_slot_ds", {31'd0, delay_slot}, 32'd1);
        redirect = 1'b0; stall = 1'b1;
        repeat (3) tick();
        chk("stall_pc", instr_address, 32'hBFC0_000C);
        chk("stall_ds", {31'd0, delay_slot}, 32'd1);
        stall = 1'b0; redirect = 1'b1; redirect_tgt = 32'hBFC0_0100;
        tick(); chk("br_tgt", instr_address, 32'hBFC0_0018);
        chk("br_tgt_ds", {31'd0, delay_slot}, 32'd0);
        redirect = 1'b0; clk_enable = 1'b0;
        tick(); tick(); chk("ce_hold", instr_address, 32'hBFC0_0018);
        clk_enable = 1'b1;
        tick(); chk("ce_resume", instr_address, 32'hBFC0_001C);

        // 4: jump to the halt address
        do_reset();
        repeat (11) tick();
        chk("jr_at", instr_address, 32'hBFC0_002C);
        redirect = 1'b1; redirect_tgt = 32'h0000_0000;
        tick(); chk("jr_slot", instr_address, 32'hBFC0_0030);
        redirect = 1'b0;
        tick(); chk("jr_tgt", instr_address, 32'h0000_0000);
        chk("jr_active", {31'd0, active}, 32'd1);
        tick(); chk("halt_active", {31'd0, active}, 32'd0);
        repeat (10) tick();
        chk("halt_pc", instr_address, 32'h0000_0000);
        chk("halt_active2", {31'd0, active}, 32'd0);

        // 6: misaligned target
        do_reset(); tick(); tick();
        redirect = 1'b1; redirect_tgt = 32'hBFC0_0022;
        tick(); chk("mis_slot", instr_address, 32'hBFC0_000C);
        redirect = 1'b0;
`ifdef PC_ALIGN_CHECK_EN
        chk("mis_err", {31'd0, addr_err}, 32'd1);
        tick(); chk("mis_halt", {31'd0, active}, 32'd0);
        chk("mis_pc", instr_address, 32'hBFC0_000C);
`else
        tick(); chk("mis_tgt", instr_address, 32'hBFC0_0020);
        chk("mis_err0", {31'd0, addr_err}, 32'd0);
`endif

        // PC wrap through 2^32 into the halt address
        do_reset();
        redirect = 1'b1; redirect_tgt = 32'hFFFF_FFF8;
        tick(); redirect = 1'b0;
        tick(); chk("wrap_a", instr_address, 32'hFFFF_FFF8);
        tick(); chk("wrap_b", instr_address, 32'hFFFF_FFFC);
        tick(); chk("wrap_c", instr_address, 32'h0000_0000);
        tick(); chk("wrap_halt", {31'd0, active}, 32'd0);

        // Reset mid-delay drops the pending target
        do_reset();
        redirect = 1'b1; redirect_tgt = 32'hBFC0_0200;
        tick(); redirect = 1'b0;
        chk("mid_ds", {31'd0, delay_slot}, 32'd1);
        reset = 1'b0;
        #1 chk("mid_rst_pc", instr_address, RV);
        chk("mid_rst_ds", {31'd0, delay_slot}, 32'd0);
        #3 reset = 1'b1;
        tick(); chk("mid_after1", instr_address, 32'hBFC0_0004);
        tick(); chk("mid_after2", instr_address, 32'hBFC0_0008);

        #10;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
